afifo_rd_fwft: RTL and testbench
================================

Name: afifo_rd_fwft

Overview:
- Read-side adapter directly downstream of the async FIFO, in the read clock domain.
- Drives the FIFO's rinc and consumes its rempty and its registered 1-cycle-latency rdata.
- Presents a first-word-fall-through valid/ready stream to the consumer, with a 2-entry skid buffer so full throughput is sustained.
- Guarantees every issued rinc pops a real word and no word is lost or duplicated under backpressure.

Parameters:
- WIDTH, 8, data word width; must match the FIFO's WIDTH.
- BUF_DEPTH, 2, skid buffer entries; fixed at 2 (the credit math below assumes it).

Ports:
- rclk  input  1  read-domain clock; single clock for the whole block.
- rrstn  input  1  asynchronous active-low reset.
- rempty  input  1  FIFO empty flag, synchronous to rclk.
- rdata  input  WIDTH  FIFO read data; valid the cycle after a cycle in which rinc=1 and rempty=0.
- rinc  output  1  FIFO read request; only ever asserted when rempty=0.
- m_valid  output  1  stream data valid.
- m_ready  input  1  consumer ready.
- m_data  output  WIDTH  stream data, head of the skid buffer.
- occupancy  output  2  number of words currently held in the skid buffer (0..2).

Behaviour:
- Reset (rrstn=0, async): buffer count=0, inflight=0, read/write pointers=0.
  - m_valid=0, rinc=0 (combinational, forced low by count/inflight=0 only via rempty).
  - m_data=0, occupancy=0.
- Internal state:
  - count (0..2): words held.
  - inflight (1 bit): registered copy of the previous cycle's rinc.
  - 2-entry circular buffer with 1-bit wr/rd pointers.
- pop = m_valid & m_ready.
- rinc = !rempty && (count + inflight - pop) < 2.
  - This is combinational in m_ready and rempty; the team accepts that path.
- Arrival: when inflight=1, rdata is written at buf[wr_ptr] at the rclk edge and wr_ptr toggles.
  - rdata is ignored when inflight=0.
- Pop: on pop, rd_ptr toggles.
- count_next = count + inflight - pop. Widths must not underflow or overflow.
  - Invariant: count + inflight <= 2 always; assert this in RTL (synthesis-off).
- m_valid = (count != 0). m_data = buf[rd_ptr] (0 when count=0 is not required; don't-care).
- Latency: rempty falls during cycle N, so rinc=1 in N, rdata is valid in N+1, captured at the end of N+1, and m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is count=1, inflight=1, pop=1, giving one word per cycle.
- Backpressure: m_ready low with count=2, inflight=0 gives rinc=0. With count=1, inflight=1, no pop, rinc=0. No overflow.
- Simultaneous arrival and pop at count=1: the new word is written and the head popped; count stays 1 and order is preserved.
- Simultaneous arrival and pop at count=2: impossible by the invariant.
- rempty rising while inflight=1: the in-flight word is still captured; rinc stops the same cycle.
- m_valid/m_data stability: once m_valid=1, m_data is held unchanged until pop (AXI-style rule; the consumer may rely on it).
- Reset mid-operation: the buffer and inflight word are discarded. The FIFO's read side (rrstn) is reset together with it, so pointers stay consistent.

Decomposition:
- Shared package: WIDTH default and the BUF_DEPTH=2 constant; no typedefs needed beyond the data word.
- No sub-module; the skid buffer is a small register array inside this block.
- Top-level integration instantiates afifo plus afifo_rd_fwft, sharing rclk/rrstn.

Test Plan:
- Reset, rempty=1, m_ready=1 for 10 cycles -> rinc=0, m_valid=0, occupancy=0 throughout.
- FIFO model preloaded with 0x11,0x22,0x33,0x44; rempty=0; m_ready=1 -> first rinc in cycle 0. m_valid rises in cycle 2 and m_data yields 0x11,0x22,0x33,0x44 on 4 consecutive cycles. rinc is high 4 cycles, then low once rempty=1.
- Same preload, m_ready=0 -> exactly 2 rinc pulses, occupancy=2, m_data holds 0x11. Raising m_ready then drains 0x11..0x44 in order with no gaps after the first.
- Random m_ready toggling (50%) over 200 words 0x00..0xC7 -> output sequence identical to input, no duplicates/drops, count+inflight<=2 every cycle.
- rempty rises in the cycle after a rinc -> the in-flight word is still delivered, no extra rinc, and m_valid drops after the last word is popped.
- Assert rrstn=0 asynchronously mid-stream with occupancy=2 -> m_valid=0 and occupancy=0 immediately (without a clock edge). After release and refill with 0xA5, the first word out is 0xA5.

Source files
------------

// File: rtl/afifo_rd_fwft_pkg.sv
// Shared constants for the async FIFO read-side FWFT adapter.
package afifo_rd_fwft_pkg;
  localparam int WIDTH_DEFAULT = 8;
  // The rinc credit rule counts against exactly two slots.
  localparam int BUF_DEPTH     = 2;
endpackage

// File: rtl/afifo_rd_fwft.sv
// Read-side adapter: turns the async FIFO's 1-cycle-latency read port into a
// first-word-fall-through valid/ready stream backed by a 2-entry skid buffer.
//
// Stream handshake: a word transfers on every rclk edge where m_valid and
// m_ready are both high; once m_valid is high it stays high and m_data stays
// unchanged until that transfer happens.
module afifo_rd_fwft
  import afifo_rd_fwft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       count;
  logic             inflight;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;
  logic [2:0]       level_next;
  logic [WIDTH-1:0] mem [BUF_DEPTH];

  assign pop = m_valid & m_ready;

  // Words held after this edge, including the one already requested last cycle.
  assign level_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign rinc      = !rempty && (level_next < 3'd2);
  assign m_valid   = (count != 2'd0);
  assign m_data    = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count    <= level_next[1:0];
      inflight <= rinc;
      // rdata only carries a real word the cycle after an accepted rinc.
      if (inflight) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge rclk) begin
    if (rrstn) begin
      assert (({1'b0, count} + {2'b00, inflight}) <= 3'd2)
        else $error("afifo_rd_fwft: count + inflight exceeds buffer depth");
    end
  end
`endif

endmodule

// File: tb/tb_afifo_rd_fwft.sv
// Bench for afifo_rd_fwft: queue-based FIFO model on the read side, expected
// word queue filled at stimulus time, and a negedge monitor that checks pops.
module tb_afifo_rd_fwft;
  import afifo_rd_fwft_pkg::*;

  localparam int W = 8;

  logic         rclk = 1'b0;
  logic         rrstn;
  logic         rempty;
  logic [W-1:0] rdata;
  logic         rinc;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  int           n_vec = 0;
  int           n_err = 0;
  int           rinc_cnt = 0;
  int           pop_cnt = 0;
  logic         rinc_q;
  logic         held_v;
  logic [W-1:0] held_d;

  afifo_rd_fwft #(.WIDTH(W)) dut (
    .rclk      (rclk),
    .rrstn     (rrstn),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  always #5 rclk = ~rclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO read-side model ----------------
  // rempty follows the queue size one edge late, like a synchronised flag.
  always @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      fifo_q.delete();
      rempty   <= 1'b1;
      rdata    <= '0;
      rinc_q   <= 1'b0;
      rinc_cnt = 0;
    end else begin
      rinc_q <= 1'b0;
      if (rinc && fifo_q.size() != 0) begin
        rdata    <= fifo_q.pop_front();
        rinc_q   <= 1'b1;
        rinc_cnt = rinc_cnt + 1;
      end
      rempty <= (fifo_q.size() == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge rclk) begin
    int exp_occ;
    if (!rrstn) begin
      pop_cnt = 0;
      held_v  = 1'b0;
    end else begin
      // Words in the buffer = words fetched, minus the one still in flight, minus words taken.
      exp_occ = rinc_cnt - int'(rinc_q) - pop_cnt;
      chk("occupancy", 32'(occupancy), 32'(exp_occ));
      chk("m_valid_vs_occ", 32'(m_valid), 32'(exp_occ != 0));
      chk("credit_limit", 32'((int'(occupancy) + int'(rinc_q)) <= 2), 32'd1);
      chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
      if (held_v) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(held_d));
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        pop_cnt = pop_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pt();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_pt();
    @(negedge rclk);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      check_pt();
      if (exp_q.size() == 0 && !m_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    int idx;
    logic [W-1:0] preload [4];
    preload[0] = 8'h11; preload[1] = 8'h22; preload[2] = 8'h33; preload[3] = 8'h44;

    rrstn   = 1'b0;
    m_ready = 1'b1;
    repeat (3) drive_pt();
    rrstn = 1'b1;

    // Idle: FIFO empty, nothing requested or presented.
    for (int i = 0; i < 10; i++) begin
      check_pt();
      chk("idle_rinc", 32'(rinc), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);
      chk("idle_occ", 32'(occupancy), 32'd0);
      drive_pt();
    end

    // Streaming with consumer always ready.
    r0 = rinc_cnt;
    for (int i = 0; i < 4; i++) load_word(preload[i]);
    check_pt();
    chk("stream_pre_rinc", 32'(rinc), 32'd0);
    check_pt();
    chk("stream_c0_rinc", 32'(rinc), 32'd1);
    chk("stream_c0_valid", 32'(m_valid), 32'd0);
    check_pt();
    chk("stream_c1_valid", 32'(m_valid), 32'd0);
    for (int c = 2; c < 6; c++) begin
      check_pt();
      chk("stream_valid", 32'(m_valid), 32'd1);
      chk("stream_data", 32'(m_data), 32'(preload[c-2]));
    end
    check_pt();
    chk("stream_end_valid", 32'(m_valid), 32'd0);
    chk("stream_rinc_count", 32'(rinc_cnt - r0), 32'd4);
    wait_drain("stream_drain", 10);

    // Backpressure: two fetches only, head held until the consumer is ready.
    drive_pt();
    m_ready = 1'b0;
    r0 = rinc_cnt;
    for (int i = 0; i < 4; i++) load_word(preload[i]);
    repeat (7) check_pt();
    chk("bp_rinc_count", 32'(rinc_cnt - r0), 32'd2);
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_head", 32'(m_data), 32'h11);
    chk("bp_rinc_low", 32'(rinc), 32'd0);
    drive_pt();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_pt();
      chk("bp_no_gap", 32'(m_valid), 32'd1);
      if (exp_q.size() == 0) break;
    end
    wait_drain("bp_drain", 10);

    // Randomised feed and consumer readiness.
    idx = 0;
    for (int c = 0; c < 3000 && idx < 200; c++) begin
      drive_pt();
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        load_word(W'(idx));
        idx++;
      end
    end
    chk("rand_all_loaded", 32'(idx), 32'd200);
    wait_drain("rand_drain", 1000);
    drive_pt();
    m_ready = 1'b1;
    wait_drain("rand_final", 10);

    // Single word: rempty rises right after the only rinc.
    drive_pt();
    r0 = rinc_cnt;
    load_word(8'h5A);
    wait_drain("single_drain", 10);
    repeat (3) check_pt();
    chk("single_rinc_count", 32'(rinc_cnt - r0), 32'd1);
    chk("single_valid_low", 32'(m_valid), 32'd0);

    // Asynchronous reset with a full buffer.
    drive_pt();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load_word(preload[i]);
    repeat (7) check_pt();
    chk("rst_pre_occ", 32'(occupancy), 32'd2);
    drive_pt();
    #2;
    rrstn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async_valid", 32'(m_valid), 32'd0);
    chk("rst_async_occ", 32'(occupancy), 32'd0);
    chk("rst_async_rinc", 32'(rinc), 32'd0);
    repeat (2) drive_pt();
    rrstn = 1'b1;
    drive_pt();
    m_ready = 1'b1;
    load_word(8'hA5);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        check_pt();
        if (m_valid) begin
          seen = 1'b1;
          chk("rst_first_word", 32'(m_data), 32'hA5);
          break;
        end
      end
      chk("rst_refill_seen", 32'(seen), 32'd1);
    end
    wait_drain("rst_drain", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
